// File: rtl/cdpga_rst_seq_pkg.sv
// Shared types and defaults for the cdpga reset sequencer.
package cdpga_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_HOLD      = 3'd3,
    ST_RUN       = 3'd4
  } rst_state_t;

  localparam int DEF_PLL_RST_CYCLES = 8;
  localparam int DEF_LOCK_TIMEOUT   = 4096;
  localparam int DEF_LOCK_FILT      = 16;
  localparam int DEF_HOLD_CYCLES    = 64;
  localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/cdpga_sync2.sv
// Generic two-flop synchronizer with synchronous active-high clear.
module cdpga_sync2 #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] meta_p0;
  logic [DATA_W-1:0] sync_p1;

  // Two flops in series; clear forces both to zero so a stale level cannot leak out.
  always_ff @(posedge clk) begin
    if (clr) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/cdpga_rst_seq.sv
// Reset sequencer between the PLL and the system: pulses PLL reset, qualifies
// lock through a filter and hold window, and releases system reset only in RUN.
module cdpga_rst_seq
  import cdpga_rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int LOCK_FILT      = DEF_LOCK_FILT,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       sw_reset_req,
  output logic       pll_reset,
  output logic       rst_out,
  output logic       rst_n_out,
  output logic       ready,
  output logic [7:0] relock_cnt,
  output logic [7:0] timeout_cnt,
  output logic [2:0] state_out
);

  localparam longint CNT_CAP = longint'(1) << CNT_W;

  if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || LOCK_FILT < 1 || HOLD_CYCLES < 1) begin : g_bad_min
    $error("cdpga_rst_seq: all cycle parameters must be >= 1");
  end
  if (longint'(PLL_RST_CYCLES - 1) >= CNT_CAP || longint'(LOCK_TIMEOUT - 1) >= CNT_CAP ||
      longint'(LOCK_FILT - 1) >= CNT_CAP || longint'(HOLD_CYCLES - 1) >= CNT_CAP) begin : g_bad_w
    $error("cdpga_rst_seq: CNT_W too narrow for the configured cycle counts");
  end

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FILT_LAST    = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic             lock_s;
  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_clr;
  logic             inc_relock;
  logic             inc_timeout;

  cdpga_sync2 #(.DATA_W(1)) u_lock_sync (
    .clk (clk),
    .clr (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // State, cycle counter and saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      relock_cnt  <= 8'd0;
      timeout_cnt <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_clr ? '0 : cnt_q + CNT_W'(1);
      if (inc_relock)  relock_cnt  <= sat_inc8(relock_cnt);
      if (inc_timeout) timeout_cnt <= sat_inc8(timeout_cnt);
    end
  end

  // Next state: software restart outranks lock loss, which outranks counter expiry.
  always_comb begin
    state_d     = state_q;
    inc_relock  = 1'b0;
    inc_timeout = 1'b0;
    if (sw_reset_req) begin
      state_d = ST_PLL_RST;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == PLL_RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_FILTER;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d     = ST_PLL_RST;
            inc_timeout = 1'b1;
          end
        end
        ST_FILTER: begin
          if (!lock_s)                 state_d = ST_WAIT_LOCK;
          else if (cnt_q == FILT_LAST) state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (!lock_s)                 state_d = ST_WAIT_LOCK;
          else if (cnt_q == HOLD_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d    = ST_WAIT_LOCK;
            inc_relock = 1'b1;
          end
        end
        default: state_d = ST_PLL_RST;
      endcase
    end
    cnt_clr = sw_reset_req || (state_d != state_q);
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    pll_reset = (state_q == ST_PLL_RST);
    ready     = (state_q == ST_RUN);
    rst_out   = ~ready;
    rst_n_out = ready;
    state_out = state_q;
  end

endmodule

// File: tb/tb_cdpga_rst_seq.sv
// Scoreboard bench for cdpga_rst_seq: stimulus queues expected state transitions,
// a monitor pops one per observed transition and compares cycle, counters and outputs.
module tb_cdpga_rst_seq;
  import cdpga_rst_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       sw_reset_req;
  logic       pll_reset;
  logic       rst_out;
  logic       rst_n_out;
  logic       ready;
  logic [7:0] relock_cnt;
  logic [7:0] timeout_cnt;
  logic [2:0] state_out;

  cdpga_rst_seq dut (
    .clk          (clk),
    .reset        (reset),
    .pll_lock     (pll_lock),
    .sw_reset_req (sw_reset_req),
    .pll_reset    (pll_reset),
    .rst_out      (rst_out),
    .rst_n_out    (rst_n_out),
    .ready        (ready),
    .relock_cnt   (relock_cnt),
    .timeout_cnt  (timeout_cnt),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ecyc;
    logic [2:0] st;
    logic [7:0] rl;
    logic [7:0] to;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  logic       mon_en = 1'b0;
  logic       watch_rst = 1'b0;
  logic       rst_low_seen = 1'b0;
  logic [2:0] prev_st;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [2:0] st, input logic [7:0] rl, input logic [7:0] to);
    exp_t x;
    x.ecyc = c; x.st = st; x.rl = rl; x.to = to;
    q.push_back(x);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(name, q.size(), 0);
    q.delete();
  endtask

  // One lock loss from RUN followed by a clean relock.
  task automatic lock_loss(input logic [7:0] rl);
    int n;
    pll_lock = 1'b0;
    n = cyc + 1;
    push(n + 2,  ST_WAIT_LOCK, rl, 8'd0);
    push(n + 5,  ST_FILTER,    rl, 8'd0);
    push(n + 21, ST_HOLD,      rl, 8'd0);
    push(n + 85, ST_RUN,       rl, 8'd0);
    wait_until(n + 2);
    pll_lock = 1'b1;
    wait_until(n + 86);
  endtask

  // Monitor: one scoreboard pop per state change seen on state_out.
  initial begin
    forever begin
      @(negedge clk);
      if (watch_rst && rst_out !== 1'b1) rst_low_seen = 1'b1;
      if (mon_en && state_out !== prev_st) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_transition: state %0d at cycle %0d, nothing queued", state_out, cyc);
        end else begin
          e = q.pop_front();
          if (cyc != e.ecyc || state_out !== e.st || relock_cnt !== e.rl || timeout_cnt !== e.to ||
              pll_reset !== (e.st == ST_PLL_RST) || ready !== (e.st == ST_RUN) ||
              rst_out !== (e.st != ST_RUN) || rst_n_out !== (e.st == ST_RUN)) begin
            fails++;
            $display("FAIL transition: got cyc=%0d st=%0d rl=%0d to=%0d pr=%b ro=%b rn=%b rdy=%b want cyc=%0d st=%0d rl=%0d to=%0d",
                     cyc, state_out, relock_cnt, timeout_cnt, pll_reset, rst_out, rst_n_out, ready,
                     e.ecyc, e.st, e.rl, e.to);
          end
        end
      end
      prev_st = state_out;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, m, p, n;
    logic [7:0] rl_exp;
    reset = 1'b1; pll_lock = 1'b1; sw_reset_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_state",     state_out,   ST_PLL_RST);
    check("rst_pll_reset", pll_reset,   1);
    check("rst_rst_out",   rst_out,     1);
    check("rst_rst_n_out", rst_n_out,   0);
    check("rst_ready",     ready,       0);
    check("rst_relock",    relock_cnt,  0);
    check("rst_timeout",   timeout_cnt, 0);
    mon_en = 1'b1;

    // Lock high from the start: minimum release latency
    reset = 1'b0; base = cyc;
    push(base + 8,  ST_WAIT_LOCK, 0, 0);
    push(base + 9,  ST_FILTER,    0, 0);
    push(base + 25, ST_HOLD,      0, 0);
    push(base + 89, ST_RUN,       0, 0);
    wait_until(base + 95);
    drain("boot_drain");
    check("boot_ready",   ready,       1);
    check("boot_relock",  relock_cnt,  0);
    check("boot_timeout", timeout_cnt, 0);

    // Lock loss in RUN and relock
    lock_loss(8'd1);
    drain("lockloss_drain");

    // sw_reset_req pulse in RUN, then a one-cycle lock glitch during FILTER
    sw_reset_req = 1'b1; m = cyc + 1;
    push(m, ST_PLL_RST, 1, 0);
    wait_until(m);
    sw_reset_req = 1'b0;
    push(m + 8, ST_WAIT_LOCK, 1, 0);
    push(m + 9, ST_FILTER,    1, 0);
    wait_until(m + 13);
    pll_lock = 1'b0;
    push(m + 16, ST_WAIT_LOCK, 1, 0);
    push(m + 17, ST_FILTER,    1, 0);
    push(m + 33, ST_HOLD,      1, 0);
    push(m + 97, ST_RUN,       1, 0);
    wait_until(m + 14);
    pll_lock = 1'b1;
    wait_until(m + 98);
    drain("glitch_drain");
    check("glitch_relock", relock_cnt, 1);

    // sw_reset_req together with lock loss: restart wins, no relock count
    pll_lock = 1'b0; sw_reset_req = 1'b1; p = cyc + 1;
    push(p, ST_PLL_RST, 1, 0);
    wait_until(p);
    sw_reset_req = 1'b0; pll_lock = 1'b1;
    push(p + 8,  ST_WAIT_LOCK, 1, 0);
    push(p + 9,  ST_FILTER,    1, 0);
    push(p + 25, ST_HOLD,      1, 0);
    push(p + 89, ST_RUN,       1, 0);
    wait_until(p + 90);
    drain("swlock_drain");
    check("swlock_relock", relock_cnt, 1);

    // Drive the relock counter into saturation
    rl_exp = 8'd1;
    for (int i = 0; i < 256; i++) begin
      rl_exp = (rl_exp == 8'hFF) ? rl_exp : rl_exp + 8'd1;
      lock_loss(rl_exp);
    end
    drain("sat_drain");
    check("sat_relock", relock_cnt, 255);

    // Reset asserted mid-HOLD
    pll_lock = 1'b0; n = cyc + 1;
    push(n + 2,  ST_WAIT_LOCK, 255, 0);
    push(n + 5,  ST_FILTER,    255, 0);
    push(n + 21, ST_HOLD,      255, 0);
    wait_until(n + 2);
    pll_lock = 1'b1;
    wait_until(n + 30);
    check("midhold_state", state_out, ST_HOLD);
    reset = 1'b1;
    push(n + 31, ST_PLL_RST, 0, 0);
    wait_until(n + 31);
    check("midhold_pll_reset", pll_reset,   1);
    check("midhold_rst_out",   rst_out,     1);
    check("midhold_rst_n_out", rst_n_out,   0);
    check("midhold_ready",     ready,       0);
    check("midhold_relock",    relock_cnt,  0);
    check("midhold_timeout",   timeout_cnt, 0);
    drain("midhold_drain");

    // Lock never arrives: three timeouts, reset never released
    pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0; base = cyc; watch_rst = 1'b1;
    push(base + 8,     ST_WAIT_LOCK, 0, 0);
    push(base + 4104,  ST_PLL_RST,   0, 1);
    push(base + 4112,  ST_WAIT_LOCK, 0, 1);
    push(base + 8208,  ST_PLL_RST,   0, 2);
    push(base + 8216,  ST_WAIT_LOCK, 0, 2);
    push(base + 12312, ST_PLL_RST,   0, 3);
    push(base + 12320, ST_WAIT_LOCK, 0, 3);
    wait_until(base + 12325);
    drain("timeout_drain");
    check("timeout_cnt3",       timeout_cnt,  3);
    check("timeout_rst_held",   rst_low_seen, 0);
    check("timeout_relock",     relock_cnt,   0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
